// File: rtl/inst_fetch.sv
// Instruction fetch stage for the multi-cycle CPU.
// One memory read per rising edge of the fetch phase, via a req/ack handshake.
// The fetched word is captured into ir, pc advances, and HALT opcodes are flagged.
// A watchdog stops the CPU if the memory never acknowledges a request.
module inst_fetch #(
   parameter int              AW       = 8,
   parameter logic [AW-1:0]   RESET_PC = '0,
   parameter logic [5:0]      HLT_OP   = 6'h3F,
   parameter int              TIMEOUT  = 15
) (
   input  logic          clk,
   input  logic          n_rst,
   input  logic          ph_f,
   output logic          mem_req,
   output logic [AW-1:0] mem_addr,
   input  logic          mem_ack,
   input  logic [31:0]   mem_rdata,
   output logic [31:0]   ir,
   output logic          ir_valid,
   output logic [AW-1:0] pc,
   output logic          stall,
   output logic          hlt,
   output logic          err
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_HALT} state_t;

   // Watchdog value at which a further cycle without ack becomes a trap.
   localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

   state_t        state_reg, state_next;
   logic          ph_f_q_reg;
   logic [AW-1:0] pc_reg;
   logic [31:0]   ir_reg;
   logic          mem_req_reg;
   logic          hlt_reg;
   logic          err_reg;
   logic [7:0]    wdog_reg;

   logic          fetch_go;
   logic          is_hlt_word;
   logic          wdog_expired;

   // Only the rising edge of the fetch phase starts a fetch; a held level does not.
   assign fetch_go     = ph_f & ~ph_f_q_reg;
   assign is_hlt_word  = (mem_rdata[31:26] == HLT_OP);
   assign wdog_expired = (wdog_reg == WDOG_LAST);

   assign mem_req  = mem_req_reg;
   assign mem_addr = pc_reg;
   assign pc       = pc_reg;
   assign ir       = ir_reg;
   assign hlt      = hlt_reg;
   assign err      = err_reg;

   // State register.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; an ack arriving on the watchdog's last cycle still wins.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: if (fetch_go && !hlt_reg) state_next = S_REQ;
         S_REQ: begin
            if (mem_ack)           state_next = S_DONE;
            else if (wdog_expired) state_next = S_HALT;
         end
         S_DONE:  state_next = hlt_reg ? S_HALT : S_IDLE;
         S_HALT:  state_next = S_HALT;
         default: state_next = S_IDLE;
      endcase
   end

   // Outputs decoded from state: stall asserts in the same cycle the fetch phase rises.
   always_comb begin
      stall    = 1'b0;
      ir_valid = 1'b0;
      case (state_reg)
         S_IDLE:  stall    = fetch_go;
         S_REQ:   stall    = 1'b1;
         S_DONE:  ir_valid = 1'b1;
         default: begin
            stall    = 1'b0;
            ir_valid = 1'b0;
         end
      endcase
   end

   // Datapath: request line, watchdog, instruction capture, pc advance and sticky flags.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         ph_f_q_reg  <= 1'b0;
         pc_reg      <= RESET_PC;
         ir_reg      <= '0;
         mem_req_reg <= 1'b0;
         hlt_reg     <= 1'b0;
         err_reg     <= 1'b0;
         wdog_reg    <= '0;
      end else begin
         ph_f_q_reg <= ph_f;
         case (state_reg)
            S_IDLE: begin
               if (fetch_go && !hlt_reg) begin
                  mem_req_reg <= 1'b1;
                  wdog_reg    <= '0;
               end
            end
            S_REQ: begin
               if (mem_ack) begin
                  ir_reg      <= mem_rdata;
                  mem_req_reg <= 1'b0;
                  // A HALT word leaves pc pointing at itself.
                  if (is_hlt_word) hlt_reg <= 1'b1;
                  else             pc_reg  <= pc_reg + AW'(1);
               end else if (wdog_expired) begin
                  mem_req_reg <= 1'b0;
                  err_reg     <= 1'b1;
                  hlt_reg     <= 1'b1;
               end else begin
                  wdog_reg <= wdog_reg + 8'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
